// File: rtl/note_frame_pkg.sv
// Shared types and constants for the note frame writer: lane count, matrix depth,
// lane-to-column mapping and the frame swap state encoding.
package note_frame_pkg;

    localparam int NUM_LANES = 4;
    localparam int ROWS      = 16;

    // Matrix column driven by each lane.
    localparam int LANE_COL [NUM_LANES] = '{32'd0, 32'd5, 32'd10, 32'd15};

    typedef logic [1:0]  lane_idx_t;
    typedef logic [15:0] lane_bits_t;

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } swap_state_t;

endpackage

// File: rtl/note_frame_writer_if.sv
// Note request handshake: the producer presents a lane index with valid, and the
// writer answers ready when that lane has no note already pending.
interface note_frame_writer_if;
    import note_frame_pkg::*;

    logic      note_valid;
    lane_idx_t note_col;
    logic      note_ready;

    modport master (output note_valid, output note_col, input  note_ready);
    modport slave  (input  note_valid, input  note_col, output note_ready);

endinterface

// File: rtl/note_lane.sv
// One falling-note lane: a pending request slot, a ROWS-deep shifter, and the
// bottom-window hit judge producing registered hit/miss pulses.
module note_lane
    import note_frame_pkg::*;
#(
    parameter int HIT_ROWS = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       accept,
    input  logic       hit,
    output lane_bits_t bits,
    output logic       pending,
    output logic       changed,
    output logic       lane_hit,
    output logic       lane_miss
);

    lane_bits_t bits_r;
    logic       pending_r;
    logic       lane_hit_r;
    logic       lane_miss_r;

    logic       window_hit_s;
    logic [3:0] clear_idx_s;
    logic       clear_s;
    lane_bits_t judged_s;
    lane_bits_t next_bits_s;
    logic       inject_s;
    logic       fall_off_s;
    logic       stray_s;

    // Judge first, then shift on tick, then inject the pending note into row 0.
    always_comb begin
        window_hit_s = 1'b0;
        clear_idx_s  = 4'd0;
        for (int r = ROWS - HIT_ROWS; r < ROWS; r++) begin
            if (bits_r[r]) begin
                window_hit_s = 1'b1;
                clear_idx_s  = r[3:0];
            end else begin
                window_hit_s = window_hit_s;
            end
        end
        clear_s  = hit & window_hit_s;
        stray_s  = hit & ~window_hit_s;
        judged_s = bits_r;
        if (clear_s) begin
            judged_s[clear_idx_s] = 1'b0;
        end else begin
            judged_s = bits_r;
        end
        fall_off_s = tick & judged_s[ROWS-1];
        inject_s   = tick & pending_r;
        if (tick) begin
            next_bits_s = {judged_s[ROWS-2:0], inject_s};
        end else begin
            next_bits_s = judged_s;
        end
    end

    assign changed   = (next_bits_s != bits_r);
    assign bits      = bits_r;
    assign pending   = pending_r;
    assign lane_hit  = lane_hit_r;
    assign lane_miss = lane_miss_r;

    // Lane state, pending slot and the one-cycle result pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bits_r      <= '0;
            pending_r   <= 1'b0;
            lane_hit_r  <= 1'b0;
            lane_miss_r <= 1'b0;
        end else begin
            bits_r      <= next_bits_s;
            lane_hit_r  <= clear_s;
            lane_miss_r <= stray_s | fall_off_s;
            // A request accepted on a tick cycle waits for the next tick.
            if (inject_s) begin
                pending_r <= 1'b0;
            end else if (accept) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: rtl/note_frame_writer.sv
// Writer side of the 16x16 LED frame: four note lanes, tear-free red publication
// on frame_done, and an optional green hit-line overlay (NOTE_FRAME_HITLINE_EN).
module note_frame_writer
    import note_frame_pkg::*;
#(
    parameter int HIT_ROWS = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    note_frame_writer_if.slave    req,
    input  logic                  tick,
    input  logic [3:0]            hit,
    input  logic                  frame_done,
    output logic [3:0]            lane_hit,
    output logic [3:0]            lane_miss,
    output logic [15:0][15:0]     RedPixels,
    output logic [15:0][15:0]     GrnPixels
);

    lane_bits_t           lane_bits_s [NUM_LANES];
    logic [NUM_LANES-1:0] pending_s;
    logic [NUM_LANES-1:0] changed_s;
    logic [NUM_LANES-1:0] accept_s;
    logic [15:0][15:0]    image_s;
    swap_state_t          state_r;

    assign req.note_ready = ~pending_s[req.note_col];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign accept_s[i] = req.note_valid & req.note_ready &
                             (req.note_col == lane_idx_t'(i));

        note_lane #(
            .HIT_ROWS (HIT_ROWS)
        ) u_lane (
            .Clock     (Clock),
            .Reset     (Reset),
            .tick      (tick),
            .accept    (accept_s[i]),
            .hit       (hit[i]),
            .bits      (lane_bits_s[i]),
            .pending   (pending_s[i]),
            .changed   (changed_s[i]),
            .lane_hit  (lane_hit[i]),
            .lane_miss (lane_miss[i])
        );
    end

    // Working image: lane bits placed in their matrix columns, others dark.
    always_comb begin
        image_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < ROWS; r++) begin
                image_s[r][LANE_COL[l]] = lane_bits_s[l][r];
            end
        end
    end

    // Dirty/swap FSM: publish the current (pre-change) image on frame_done.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= CLEAN;
            RedPixels <= '0;
        end else begin
            case (state_r)
                CLEAN: begin
                    RedPixels <= RedPixels;
                    if (|changed_s) begin
                        state_r <= DIRTY;
                    end else begin
                        state_r <= CLEAN;
                    end
                end
                DIRTY: begin
                    if (frame_done) begin
                        RedPixels <= image_s;
                        state_r   <= (|changed_s) ? DIRTY : CLEAN;
                    end else begin
                        RedPixels <= RedPixels;
                        state_r   <= DIRTY;
                    end
                end
                default: begin
                    RedPixels <= '0;
                    state_r   <= DIRTY;
                end
            endcase
        end
    end

`ifdef NOTE_FRAME_HITLINE_EN
    // Hit-line overlay: bottom window rows lit once reset releases.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            GrnPixels <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                GrnPixels[r] <= (r >= ROWS - HIT_ROWS) ? 16'hFFFF : 16'h0000;
            end
        end
    end
`else
    assign GrnPixels = '0;
`endif

endmodule

// File: tb/tb_note_frame_writer.sv
// Directed bench for note_frame_writer: expected lane_hit/lane_miss pulses are
// queued with each driven cycle and popped after the clock edge.
module tb_note_frame_writer;
    import note_frame_pkg::*;

    logic              Clock;
    logic              Reset;
    logic              tick;
    logic [3:0]        hit;
    logic              frame_done;
    logic [3:0]        lane_hit;
    logic [3:0]        lane_miss;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    note_frame_writer_if bus ();

    note_frame_writer #(.HIT_ROWS(2)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req        (bus),
        .tick       (tick),
        .hit        (hit),
        .frame_done (frame_done),
        .lane_hit   (lane_hit),
        .lane_miss  (lane_miss),
        .RedPixels  (RedPixels),
        .GrnPixels  (GrnPixels)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [255:0] px(input int row, input int col);
        logic [255:0] v;
        v = '0;
        v[row*16 + col] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] grn_exp();
        logic [255:0] v;
        v = '0;
`ifdef NOTE_FRAME_HITLINE_EN
        for (int c = 0; c < 16; c++) begin
            v[14*16 + c] = 1'b1;
            v[15*16 + c] = 1'b1;
        end
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; expected pulses are queued, then checked.
    task automatic cyc(input logic tk, input logic [3:0] h, input logic fd,
                       input logic nv, input logic [1:0] nc,
                       input logic [3:0] eh, input logic [3:0] em);
        logic [7:0] e;
        tick = tk; hit = h; frame_done = fd;
        bus.note_valid = nv; bus.note_col = nc;
        exp_q.push_back({eh, em});
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        chk("lane_hit", 256'(lane_hit), 256'(e[7:4]));
        chk("lane_miss", 256'(lane_miss), 256'(e[3:0]));
        tick = 1'b0; hit = 4'b0000; frame_done = 1'b0; bus.note_valid = 1'b0;
    endtask

    task automatic ready_chk(input logic [1:0] col, input logic exp);
        bus.note_col = col;
        #1;
        chk("note_ready", 256'(bus.note_ready), 256'(exp));
    endtask

    initial begin
        Reset = 1'b1; tick = 1'b0; hit = 4'b0000; frame_done = 1'b0;
        bus.note_valid = 1'b0; bus.note_col = 2'd0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_red", RedPixels, '0);
        chk("reset_grn", GrnPixels, '0);
        chk("reset_hit", 256'(lane_hit), '0);
        chk("reset_miss", 256'(lane_miss), '0);
        ready_chk(2'd2, 1'b1);
        Reset = 1'b0;
        cyc(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("grn_after_reset", GrnPixels, grn_exp());

        // Lane 2: accept, refused second request, tick injects, second accepted.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000);
        ready_chk(2'd2, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);
        ready_chk(2'd2, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000);
        ready_chk(2'd2, 1'b0);
        chk("red_held_no_frame", RedPixels, '0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_first_note", RedPixels, px(0, 10));

        // Stray hit on an empty lane 3: single-cycle miss, pixels untouched.
        cyc(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b1000);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_after_stray", RedPixels, px(0, 10));

        // Lane 0 note plus both lane 2 notes fall through 17 ticks.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
        for (int k = 1; k <= 17; k++) begin
            cyc(1'b1, 4'b0000, (k == 6), 1'b0, 2'd0, 4'b0000,
                (k == 16) ? 4'b0100 : ((k == 17) ? 4'b0101 : 4'b0000));
            if (k == 5) begin
                chk("red_hold_k5", RedPixels, px(0, 10));
            end
            if (k == 6) begin
                chk("red_pre_change", RedPixels, px(4, 0) | px(5, 10) | px(4, 10));
                cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
                chk("red_after_change", RedPixels, px(5, 0) | px(6, 10) | px(5, 10));
            end
        end
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_all_fallen", RedPixels, '0);

        // Lane 1 note reaches row 15, then hit and tick together.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        end
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_row15", RedPixels, px(15, 5));
        cyc(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0010, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_lane1_cleared", RedPixels, '0);

        // Lane 3 note at row 14 (top of window) is hit without a tick.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000);
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        end
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_row14", RedPixels, px(14, 15));
        cyc(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_lane3_cleared", RedPixels, '0);
        chk("grn_steady", GrnPixels, grn_exp());

        // Asynchronous reset blanks the published frame at once.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
        chk("red_before_reset", RedPixels, px(0, 0));
        #1;
        Reset = 1'b1;
        #1;
        chk("red_async_reset", RedPixels, '0);
        chk("grn_async_reset", GrnPixels, '0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
